fifo4_wr_sched: RTL and testbench



---
 rtl/fifo4_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/fifo4_wr_sched.sv | 116 +++++++++++
 tb/tb_fifo4_wr_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo4_sched_pkg.sv
// rtl/fifo4_sched_pkg.sv - shared types and sizing helpers for the fifo4 write scheduler
package fifo4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        RECOV
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Recovery must outlast the synchroniser so the updated full flag is seen in IDLE.
    function automatic int rc_eff(input int rc, input int sync);
        return max_int(rc, sync + 1);
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int          c;
    logic [IW-1:0] cw;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        cw  = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            cw = IW'(c);
            if (!any && req[cw]) begin
                any     = 1'b1;
                idx     = cw;
                gnt[cw] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo4_wr_sched.sv
// rtl/fifo4_wr_sched.sv - round-robin write scheduler driving the self-timed fifo4 write port
module fifo4_wr_sched
    import fifo4_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int PW   = 2,
    parameter int RC   = 3,
    parameter int SYNC = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      wdata,
    output logic [N-1:0]         ack,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic [DW-1:0]        fifo_din,
    output logic                 fifo_write,
    input  logic                 fifo_full,
    output logic                 fifo_clr
);

    localparam int IW     = $clog2(N);
    localparam int RC_EFF = rc_eff(RC, SYNC);
    localparam int CW     = cnt_width(max_int(PW, RC_EFF));
    localparam logic [N-1:0] ACK_ONE = {{(N-1){1'b0}}, 1'b1};

    sched_state_t  state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic [SYNC-1:0] sync_q;
    logic          full_s;
    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          arb_any;

    assign full_s = sync_q[SYNC-1];

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Reset to all ones: treat the FIFO as full until clean samples arrive.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], fifo_full};
        end
    end

    always_ff @(posedge clk) begin
        fifo_clr <= clr;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            fifo_write <= 1'b0;
            fifo_din   <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any && !full_s) begin
                        fifo_din <= wdata[int'(arb_idx)*DW +: DW];
                        grant_id <= arb_idx;
                        ptr      <= (arb_idx == IW'(N-1)) ? '0 : arb_idx + 1'b1;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    fifo_write <= 1'b1;
                    cnt        <= '0;
                    state      <= PULSE;
                end
                PULSE: begin
                    if (cnt == CW'(PW-1)) begin
                        fifo_write <= 1'b0;
                        ack        <= ACK_ONE << grant_id;
                        cnt        <= '0;
                        state      <= RECOV;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECOV: begin
                    ack <= '0;
                    if (cnt == CW'(RC_EFF-1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_gnt;
    assign unused_gnt = ^arb_gnt;

endmodule

// File: tb/tb_fifo4_wr_sched.sv
// tb/tb_fifo4_wr_sched.sv - directed self-checking bench for fifo4_wr_sched
module tb_fifo4_wr_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] wdata = '0;
    logic            fifo_full = 1'b0;
    logic [N-1:0]    ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic [DW-1:0]   fifo_din;
    logic            fifo_write;
    logic            fifo_clr;

    fifo4_wr_sched #(.N(N), .DW(DW), .PW(2), .RC(3), .SYNC(2)) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .wdata      (wdata),
        .ack        (ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .fifo_din   (fifo_din),
        .fifo_write (fifo_write),
        .fifo_full  (fifo_full),
        .fifo_clr   (fifo_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] fq[$];
    int         wr_cyc[$];
    logic [7:0] wr_dat[$];
    logic [1:0] wr_gid[$];
    logic       rd_req = 1'b0;
    logic       auto_drain = 1'b0;
    logic       wr_prev = 1'b0;
    logic [7:0] din_prev = '0;
    int         mon_fail = 0;

    // Behavioural fifo4: captures on the rising edge of write, full at 4 entries.
    always @(posedge clk) begin
        #1;
        if (fifo_write && wr_prev && fifo_din !== din_prev) begin
            mon_fail++;
            $display("FAIL din_stable: fifo_din=%h was %h during write", fifo_din, din_prev);
        end
        if (fifo_write && !busy) begin
            mon_fail++;
            $display("FAIL write_idle: fifo_write=1 while busy=0");
        end
        if (!$onehot0(ack) || (ack != 0 && !busy)) begin
            mon_fail++;
            $display("FAIL ack_onehot: ack=%b busy=%b", ack, busy);
        end
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_write && !wr_prev) begin
                wr_cyc.push_back(cyc);
                wr_dat.push_back(fifo_din);
                wr_gid.push_back(grant_id);
                if (fq.size() < 4) fq.push_back(fifo_din);
            end
            if ((rd_req || auto_drain) && fq.size() > 0) void'(fq.pop_front());
        end
        wr_prev   = fifo_write;
        din_prev  = fifo_din;
        fifo_full = (fq.size() >= 4);
    end

    int compared = 0;
    int failed   = 0;

    task automatic do_reset();
        clr = 1'b1;
        req = '0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        compared++;
        if (i == 30) begin
            failed++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic wait_ack();
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack != 0) break;
        end
        compared++;
        if (i == 30) begin
            failed++;
            $display("FAIL ack_timeout: ack=%b required nonzero", ack);
        end
    endtask

    task automatic wait_writes(input int target, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (wr_cyc.size() >= target) break;
            @(negedge clk);
        end
        compared++;
        if (wr_cyc.size() < target) begin
            failed++;
            $display("FAIL write_timeout: writes=%0d required %0d", wr_cyc.size(), target);
        end
    endtask

    task automatic test_reset();
        logic exp_w;
        logic [N-1:0] exp_a;
        logic exp_b;
        clr = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({fifo_write, busy, ack, grant_id, fifo_din, fifo_clr} !== {1'b0, 1'b0, 4'b0, 2'b0, 8'h00, 1'b1}) begin
            failed++;
            $display("FAIL reset_state: w=%b busy=%b ack=%b gid=%0d din=%h fclr=%b required 0 0 0000 0 00 1",
                     fifo_write, busy, ack, grant_id, fifo_din, fifo_clr);
        end
        clr = 1'b0;
        req = 4'b0001;
        wdata[7:0] = 8'hA5;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_w = (k == 4 || k == 5);
            exp_a = (k == 6) ? 4'b0001 : 4'b0000;
            exp_b = (k >= 3 && k <= 8);
            compared++;
            if (fifo_write !== exp_w || ack !== exp_a || busy !== exp_b) begin
                failed++;
                $display("FAIL first_xfer_c%0d: w=%b ack=%b busy=%b required %b %b %b",
                         k, fifo_write, ack, busy, exp_w, exp_a, exp_b);
            end
            if (k == 1) begin
                compared++;
                if (fifo_clr !== 1'b0) begin
                    failed++;
                    $display("FAIL fifo_clr_release: fifo_clr=%b required 0", fifo_clr);
                end
            end
            if (k == 3) begin
                compared++;
                if (fifo_din !== 8'hA5 || grant_id !== 2'd0) begin
                    failed++;
                    $display("FAIL first_din: din=%h gid=%0d required a5 0", fifo_din, grant_id);
                end
            end
            if (k == 6) req = '0;
        end
        compared++;
        if (fq.size() != 1 || fq[0] !== 8'hA5) begin
            failed++;
            $display("FAIL first_fifo: size=%0d required 1 with a5", fq.size());
        end
    endtask

    task automatic test_round_robin();
        int base;
        do_reset();
        auto_drain = 1'b1;
        for (int i = 0; i < N; i++) wdata[i*DW +: DW] = 8'h10 + 8'(i);
        req = 4'b1111;
        base = wr_cyc.size();
        wait_writes(base + 5, 80);
        req = '0;
        if (wr_cyc.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (wr_dat[base+i] !== 8'h10 + 8'(i % 4) || wr_gid[base+i] !== 2'(i % 4)) begin
                    failed++;
                    $display("FAIL rr_order_%0d: data=%h gid=%0d required %h %0d",
                             i, wr_dat[base+i], wr_gid[base+i], 8'h10 + 8'(i % 4), i % 4);
                end
                if (i > 0) begin
                    compared++;
                    if (wr_cyc[base+i] - wr_cyc[base+i-1] != 7) begin
                        failed++;
                        $display("FAIL rr_spacing_%0d: gap=%0d required 7",
                                 i, wr_cyc[base+i] - wr_cyc[base+i-1]);
                    end
                end
            end
        end
        wait_idle();
        auto_drain = 1'b0;
    endtask

    task automatic test_full();
        int base;
        int base2;
        int cf;
        int acks;
        do_reset();
        wdata[7:0] = 8'h20;
        req = 4'b0001;
        base = wr_cyc.size();
        wait_writes(base + 4, 60);
        req = '0;
        wait_idle();
        compared++;
        if (fifo_full !== 1'b1 || fq.size() != 4) begin
            failed++;
            $display("FAIL fill: full=%b size=%0d required 1 4", fifo_full, fq.size());
        end
        wdata[23:16] = 8'h77;
        req = 4'b0100;
        base2 = wr_cyc.size();
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack != 0) acks++;
        end
        compared++;
        if (wr_cyc.size() != base2 || acks != 0) begin
            failed++;
            $display("FAIL blocked_full: writes=%0d acks=%0d required %0d 0",
                     wr_cyc.size(), acks, base2);
        end
        rd_req = 1'b1;
        @(negedge clk);
        cf = cyc;
        rd_req = 1'b0;
        wait_writes(base2 + 1, 10);
        if (wr_cyc.size() > base2) begin
            compared++;
            if (wr_cyc[base2] - cf != 4 || wr_dat[base2] !== 8'h77 || wr_gid[base2] !== 2'd2) begin
                failed++;
                $display("FAIL unblock: delay=%0d data=%h gid=%0d required 4 77 2",
                         wr_cyc[base2] - cf, wr_dat[base2], wr_gid[base2]);
            end
        end
        wait_ack();
        compared++;
        if (ack !== 4'b0100) begin
            failed++;
            $display("FAIL unblock_ack: ack=%b required 0100", ack);
        end
        req = '0;
        wait_idle();
        compared++;
        if (fq.size() != 4 || fq[3] !== 8'h77) begin
            failed++;
            $display("FAIL unblock_fifo: size=%0d required 4 ending 77", fq.size());
        end
    endtask

    task automatic test_clr_mid();
        int i;
        int base;
        do_reset();
        wdata[15:8] = 8'h5A;
        req = 4'b0010;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_write) break;
        end
        @(negedge clk);
        compared++;
        if (fifo_write !== 1'b1 || fq.size() != 1) begin
            failed++;
            $display("FAIL clr_pulse2: w=%b size=%0d required 1 1", fifo_write, fq.size());
        end
        clr = 1'b1;
        req = '0;
        @(negedge clk);
        compared++;
        if (fifo_write !== 1'b0 || busy !== 1'b0 || ack !== 4'b0 || fifo_clr !== 1'b1 || grant_id !== 2'd0) begin
            failed++;
            $display("FAIL clr_abort: w=%b busy=%b ack=%b fclr=%b gid=%0d required 0 0 0000 1 0",
                     fifo_write, busy, ack, fifo_clr, grant_id);
        end
        repeat (2) @(negedge clk);
        clr = 1'b0;
        compared++;
        if (fq.size() != 0 || ack !== 4'b0) begin
            failed++;
            $display("FAIL clr_empty: size=%0d ack=%b required 0 0000", fq.size(), ack);
        end
        for (int k = 0; k < N; k++) wdata[k*DW +: DW] = 8'h30 + 8'(k);
        req = 4'b1111;
        base = wr_cyc.size();
        wait_writes(base + 1, 12);
        if (wr_cyc.size() > base) begin
            compared++;
            if (wr_gid[base] !== 2'd0 || wr_dat[base] !== 8'h30) begin
                failed++;
                $display("FAIL clr_ptr: gid=%0d data=%h required 0 30", wr_gid[base], wr_dat[base]);
            end
        end
        wait_ack();
        req = '0;
        wait_idle();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_a;
        do_reset();
        auto_drain = 1'b1;
        wdata[7:0]  = 8'hC0;
        wdata[15:8] = 8'hC1;
        req = 4'b0011;
        for (int t = 0; t < 20; t++) begin
            wait_ack();
            exp_a = (t % 2 == 0) ? 4'b0001 : 4'b0010;
            compared++;
            if (ack !== exp_a) begin
                failed++;
                $display("FAIL fair_%0d: ack=%b required %b", t, ack, exp_a);
            end
            req = req & ~ack;
            @(negedge clk);
            req = 4'b0011;
        end
        req = '0;
        wait_idle();
        auto_drain = 1'b0;
    endtask

    initial begin
        test_reset();
        wait_idle();
        test_round_robin();
        test_full();
        test_clr_mid();
        test_fairness();
        repeat (2) @(negedge clk);
        compared++;
        if (mon_fail != 0) begin
            failed++;
            $display("FAIL cycle_monitor: violations=%0d required 0", mon_fail);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
